// File: rtl/hfswr_rx_pkg.sv
// Shared types and sizing helpers for the HFSWR receive capture path.
package hfswr_rx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CAPTURE  = 2'd1,
      ST_WAIT_LOW = 2'd2
   } rx_state_e;

   function automatic int bank_w(input int n_banks);
      return (n_banks > 1) ? $clog2(n_banks) : 1;
   endfunction

   function automatic int len_w(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/rx_bank_tracker.sv
// Bank occupancy bookkeeping: full mask, write/read pointers, stored
// window lengths and the readout handshake.
module rx_bank_tracker
   import hfswr_rx_pkg::*;
#(
   parameter int N_BANKS = 2,
   parameter int ADDR_W  = 12,
   localparam int BANK_W = bank_w(N_BANKS),
   localparam int LEN_W  = len_w(ADDR_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              close_i,
   input  logic [LEN_W-1:0]  close_len_i,
   input  logic              ack_i,
   output logic              wr_free_o,
   output logic [BANK_W-1:0] wr_bank_o,
   output logic              rdy_o,
   output logic [BANK_W-1:0] rdy_bank_o,
   output logic [LEN_W-1:0]  rdy_len_o
);

   logic [N_BANKS-1:0] full_q, full_d;
   logic [BANK_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [BANK_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LEN_W-1:0]   len_q [N_BANKS];
   logic               ack_ok;

   assign ack_ok = ack_i & full_q[rd_ptr_q];

   // An ack releasing the very bank the next window needs counts as free.
   assign wr_free_o = ~full_q[wr_ptr_q]
                    | (ack_ok & (rd_ptr_q == wr_ptr_q));

   assign wr_bank_o  = wr_ptr_q;
   assign rdy_o      = full_q[rd_ptr_q];
   assign rdy_bank_o = rd_ptr_q;
   assign rdy_len_o  = len_q[rd_ptr_q];

   always_comb begin
      full_d   = full_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (ack_ok) begin
         full_d[rd_ptr_q] = 1'b0;
         rd_ptr_d = (rd_ptr_q == BANK_W'(N_BANKS - 1))
                  ? '0 : rd_ptr_q + 1'b1;
      end
      if (close_i) begin
         full_d[wr_ptr_q] = 1'b1;
         wr_ptr_d = (wr_ptr_q == BANK_W'(N_BANKS - 1))
                  ? '0 : wr_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < N_BANKS; i++) begin
            len_q[i] <= '0;
         end
      end else begin
         full_q   <= full_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (close_i) begin
            len_q[wr_ptr_q] <= close_len_i;
         end
      end
   end

endmodule

// File: rtl/rx_bram_bank_ctrl.sv
// Gates sample strobes with the pulse window and writes each window
// into the next free BRAM bank, publishing closed banks in order.
module rx_bram_bank_ctrl
   import hfswr_rx_pkg::*;
#(
   parameter int N_BANKS = 2,
   parameter int ADDR_W  = 12,
   parameter int DEPTH   = 4096,
   parameter int WE_W    = 4,
   localparam int BANK_W = bank_w(N_BANKS),
   localparam int LEN_W  = len_w(ADDR_W)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               sinc,
   input  logic               ack,
   output logic [N_BANKS-1:0] en_bank,
   output logic [WE_W-1:0]    we,
   output logic [ADDR_W-1:0]  addr,
   output logic               rst_count,
   output logic               rdy,
   output logic [BANK_W-1:0]  rdy_bank,
   output logic [LEN_W-1:0]   rdy_len,
   output logic               ovf
);

   rx_state_e          state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               sinc_q;
   logic               ovf_q, ovf_d;
   logic               rst_count_q;
   logic [N_BANKS-1:0] en_bank_q;
   logic [WE_W-1:0]    we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic               rise;
   logic               wr_en;
   logic               close;
   logic               wr_free;
   logic [BANK_W-1:0]  wr_bank;

   assign rise = sinc & ~sinc_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      wr_en   = 1'b0;
      close   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise) begin
               if (wr_free) begin
                  state_d = ST_CAPTURE;
               end else begin
                  ovf_d   = 1'b1;
                  state_d = ST_WAIT_LOW;
               end
            end
         end
         ST_CAPTURE: begin
            if (cnt_q == LEN_W'(DEPTH)) begin
               // Close one edge after the last write pulse.
               close   = 1'b1;
               cnt_d   = '0;
               state_d = sinc ? ST_WAIT_LOW : ST_IDLE;
            end else if (!sinc) begin
               close   = (cnt_q != '0);
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (en) begin
               wr_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_LOW: begin
            if (!sinc) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         sinc_q      <= 1'b0;
         ovf_q       <= 1'b0;
         rst_count_q <= 1'b1;
         en_bank_q   <= '0;
         we_q        <= '0;
         addr_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sinc_q      <= sinc;
         ovf_q       <= ovf_d;
         rst_count_q <= (state_d != ST_CAPTURE);
         we_q        <= wr_en ? '1 : '0;
         en_bank_q   <= wr_en ? (N_BANKS'(1) << wr_bank) : '0;
         if (wr_en) begin
            addr_q <= cnt_q[ADDR_W-1:0];
         end
      end
   end

   rx_bank_tracker #(
      .N_BANKS (N_BANKS),
      .ADDR_W  (ADDR_W)
   ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .close_i     (close),
      .close_len_i (cnt_q),
      .ack_i       (ack),
      .wr_free_o   (wr_free),
      .wr_bank_o   (wr_bank),
      .rdy_o       (rdy),
      .rdy_bank_o  (rdy_bank),
      .rdy_len_o   (rdy_len)
   );

   assign en_bank   = en_bank_q;
   assign we        = we_q;
   assign addr      = addr_q;
   assign rst_count = rst_count_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_rx_bram_bank_ctrl.sv
// Directed bench for rx_bram_bank_ctrl with two banks of eight words.
module tb_rx_bram_bank_ctrl;

   localparam int N_BANKS = 2;
   localparam int ADDR_W  = 3;
   localparam int DEPTH   = 8;
   localparam int WE_W    = 4;

   logic               clk;
   logic               rst;
   logic               en;
   logic               sinc;
   logic               ack;
   logic [N_BANKS-1:0] en_bank;
   logic [WE_W-1:0]    we;
   logic [ADDR_W-1:0]  addr;
   logic               rst_count;
   logic               rdy;
   logic [0:0]         rdy_bank;
   logic [ADDR_W:0]    rdy_len;
   logic               ovf;

   int errors = 0;
   int checks = 0;

   rx_bram_bank_ctrl #(
      .N_BANKS (N_BANKS),
      .ADDR_W  (ADDR_W),
      .DEPTH   (DEPTH),
      .WE_W    (WE_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .sinc      (sinc),
      .ack       (ack),
      .en_bank   (en_bank),
      .we        (we),
      .addr      (addr),
      .rst_count (rst_count),
      .rdy       (rdy),
      .rdy_bank  (rdy_bank),
      .rdy_len   (rdy_len),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".en_bank"}, 32'(en_bank), 0);
      chk({tag, ".we"}, 32'(we), 0);
      chk({tag, ".addr"}, 32'(addr), 0);
      chk({tag, ".rst_count"}, 32'(rst_count), 1);
      chk({tag, ".rdy"}, 32'(rdy), 0);
      chk({tag, ".rdy_bank"}, 32'(rdy_bank), 0);
      chk({tag, ".rdy_len"}, 32'(rdy_len), 0);
      chk({tag, ".ovf"}, 32'(ovf), 0);
   endtask

   task automatic do_reset();
      en = 0; sinc = 0; ack = 0;
      rst = 1;
      step();
      step();
      rst = 0;
      step();
   endtask

   // Rise, n strobes, then sinc low (with a stray en that must be dropped).
   task automatic window(input int n);
      sinc = 1; en = 0;
      step();
      en = 1;
      for (int i = 0; i < n; i++) step();
      sinc = 0;
      step();
      en = 0;
   endtask

   initial begin
      rst = 1; en = 0; sinc = 0; ack = 0;
      #1;
      chk_reset_vals("por");
      do_reset();
      chk_reset_vals("rst1");

      // Full window: 10 strobes, only 8 written.
      sinc = 1;
      step();
      chk("s1.rst_count_cap", 32'(rst_count), 0);
      en = 1;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("s1.we", 32'(we), 32'hF);
         chk("s1.en_bank", 32'(en_bank), 1);
         chk("s1.addr", 32'(addr), i);
      end
      step();
      chk("s1.we9", 32'(we), 0);
      chk("s1.rdy", 32'(rdy), 1);
      chk("s1.rdy_len", 32'(rdy_len), 8);
      chk("s1.rdy_bank", 32'(rdy_bank), 0);
      step();
      chk("s1.we10", 32'(we), 0);
      chk("s1.addr_hold", 32'(addr), 7);
      en = 0; sinc = 0;
      step();
      chk("s1.rst_count_end", 32'(rst_count), 1);

      // Short window then second bank, then ack.
      do_reset();
      window(5);
      chk("s2.we_on_low", 32'(we), 0);
      chk("s2.rdy", 32'(rdy), 1);
      chk("s2.rdy_len", 32'(rdy_len), 5);
      sinc = 1;
      step();
      en = 1;
      step();
      chk("s2.en_bank1", 32'(en_bank), 2);
      chk("s2.addr0", 32'(addr), 0);
      step();
      step();
      sinc = 0; en = 0;
      step();
      chk("s2.rdy_bank_before", 32'(rdy_bank), 0);
      ack = 1;
      step();
      ack = 0;
      chk("s2.rdy_after_ack", 32'(rdy), 1);
      chk("s2.rdy_bank_after", 32'(rdy_bank), 1);
      chk("s2.rdy_len_after", 32'(rdy_len), 3);
      ack = 1;
      step();
      ack = 0;
      chk("s2.rdy_empty", 32'(rdy), 0);
      ack = 1;
      step();
      ack = 0;
      chk("s2.ack_ignored", 32'(rdy_bank), 0);

      // Overflow with both banks full.
      do_reset();
      window(8);
      window(8);
      chk("s3.rdy", 32'(rdy), 1);
      chk("s3.ovf0", 32'(ovf), 0);
      sinc = 1;
      step();
      chk("s3.ovf", 32'(ovf), 1);
      en = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("s3.no_we", 32'(we), 0);
      end
      en = 0; sinc = 0;
      step();
      ack = 1;
      step();
      ack = 0;
      chk("s3.rdy_bank", 32'(rdy_bank), 1);
      chk("s3.ovf_sticky", 32'(ovf), 1);
      chk("s3.rdy_len", 32'(rdy_len), 8);

      // Ack and rise in the same cycle on the bank being freed.
      do_reset();
      window(8);
      window(8);
      sinc = 1; ack = 1;
      step();
      ack = 0; en = 1;
      chk("s4.rdy_bank_next", 32'(rdy_bank), 1);
      step();
      chk("s4.we", 32'(we), 32'hF);
      chk("s4.en_bank", 32'(en_bank), 1);
      chk("s4.addr", 32'(addr), 0);
      step();
      step();
      sinc = 0; en = 0;
      step();
      chk("s4.ovf", 32'(ovf), 0);
      ack = 1;
      step();
      ack = 0;
      chk("s4.rdy_bank0", 32'(rdy_bank), 0);
      chk("s4.rdy_len", 32'(rdy_len), 3);

      // Zero-length window leaves the write pointer alone.
      do_reset();
      sinc = 1;
      step();
      step();
      step();
      sinc = 0;
      step();
      chk("s5.rdy", 32'(rdy), 0);
      chk("s5.rst_count", 32'(rst_count), 1);
      sinc = 1;
      step();
      en = 1;
      step();
      chk("s5.en_bank", 32'(en_bank), 1);
      step();
      sinc = 0; en = 0;
      step();
      chk("s5.rdy_bank", 32'(rdy_bank), 0);
      chk("s5.rdy_len", 32'(rdy_len), 2);

      // Reset in the middle of a window.
      do_reset();
      sinc = 1;
      step();
      en = 1;
      for (int i = 0; i < 4; i++) step();
      chk("s6.addr3", 32'(addr), 3);
      rst = 1;
      #1;
      chk_reset_vals("s6.async");
      en = 0; sinc = 0;
      step();
      rst = 0;
      step();
      chk_reset_vals("s6.after");
      sinc = 1;
      step();
      en = 1;
      step();
      chk("s6.en_bank", 32'(en_bank), 1);
      chk("s6.addr0", 32'(addr), 0);
      chk("s6.we", 32'(we), 32'hF);
      en = 0; sinc = 0;
      step();
      chk("s6.rdy_len", 32'(rdy_len), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rx_bram_bank_ctrl.md
# rx_bram_bank_ctrl

Parametrised multi-bank capture controller for the HFSWR receiver: it gates incoming sample strobes with the pulse-window signal `sinc` and writes each window into the next of `N_BANKS` BRAM banks. It produces per-bank enable, byte write-enable and address, and publishes completed banks to the readout side through a `rdy`/`ack` handshake in capture order. It flags a window that arrives while every bank is still waiting for readout. It sits between the ADC/decimator sample stream and the BRAM ports read by the PS DMA.

## Interface
- `N_BANKS`, 2: number of capture banks, ≥2.
- `ADDR_W`, 12: BRAM word address width.
- `DEPTH`, 4096: maximum samples per window, 1..2^ADDR_W.
- `WE_W`, 4: byte-lane write-enable width.
- `clk`  in  1  sample clock, single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sample-valid strobe, one cycle per sample.
- `sinc`  in  1  reception window, level; high means capture.
- `ack`  in  1  readout has consumed bank `rdy_bank`.
- `en_bank`  out  N_BANKS  one-hot BRAM enable of the bank being written.
- `we`  out  WE_W  byte write enable, all ones on a write.
- `addr`  out  ADDR_W  write address.
- `rst_count`  out  1  high whenever no capture is in progress (sample counter held at 0).
- `rdy`  out  1  at least one bank is full and unread.
- `rdy_bank`  out  clog2(N_BANKS)  oldest unread bank.
- `rdy_len`  out  ADDR_W+1  sample count in `rdy_bank`.
- `ovf`  out  1  sticky: a window was dropped.

## Operation
- Edge detect is internal: `sinc_q` is `sinc` registered. A rise is `sinc & ~sinc_q`.
- FSM states:
  - IDLE: `rst_count`=1, counter=0.
    - Rise and `full[wr_ptr]` clear after this cycle's `ack` → CAPTURE.
    - Rise and bank still full → `ovf`<=1, go to WAIT_LOW.
  - CAPTURE: counts accepted samples.
    - When `en` and `sinc` are both high: write at `addr`=count, then count++.
    - Count reaches DEPTH → close the bank, go to WAIT_LOW.
    - `sinc` sampled low → close the bank if count>0, go to IDLE. `en` in that cycle is not written.
  - WAIT_LOW: all `en` ignored. `sinc` low → IDLE.
- Closing a bank:
  - `full[wr_ptr]`<=1, `len[wr_ptr]`<=count, `wr_ptr`<=`wr_ptr`+1 mod N_BANKS.
  - A zero-length window sets nothing and does not advance `wr_ptr`.
- Readout handshake:
  - `rdy`=`full[rd_ptr]`, `rdy_bank`=`rd_ptr`, `rdy_len`=`len[rd_ptr]`.
  - `ack` while `rdy` is high clears `full[rd_ptr]` and advances `rd_ptr`.
  - `ack` while `rdy` is low is ignored.
  - `rdy` stays high until acked.
- Simultaneous events:
  - `ack` freeing bank X and a rise needing bank X in the same cycle: the capture proceeds, because the ack is applied first.
  - `ack` and a bank close in the same cycle update different `full` bits, so both take effect.
- `ovf` clears only on `rst`.
- Reset at any point:
  - Outputs: `en_bank`=0, `we`=0, `addr`=0, `rst_count`=1, `rdy`=0, `rdy_bank`=0, `rdy_len`=0, `ovf`=0.
  - Internal state: `full`=0, both pointers=0, FSM=IDLE, `sinc_q`=0.
  - A partially written window is discarded.

## Timing
- All outputs are registered.
- Write latency is 1 cycle: `en` sampled at edge k in CAPTURE gives `we`, `en_bank` and `addr` valid for exactly the cycle after edge k. Outside write cycles they are 0; `addr` holds its last value.
- Capture start: a rise sampled at edge k puts the FSM in CAPTURE after edge k. `en` at edge k itself is not written.
- Close: `rdy` and `rdy_len` update at the edge after the last `we` pulse, or at the edge where `sinc` low is sampled.
- `ack` sampled at edge k → `rdy`/`rdy_bank` reflect the next bank after edge k.
- Sustained throughput is one sample per clock.

## Structure
- Package `hfswr_rx_pkg`: FSM state encoding (IDLE, CAPTURE, WAIT_LOW) and the `BANK_W`=clog2(N_BANKS) helper. Constant `LEN_W`=ADDR_W+1.
- Sub-module `rx_bank_tracker`: `full` mask, `wr_ptr`/`rd_ptr`, per-bank `len` registers, `ack` handling and the "next bank free" flag. The top holds the FSM, edge detect, counter and write-port registers.

## Test plan
All scenarios use N_BANKS=2, DEPTH=8, ADDR_W=3.
- Reset, then `sinc` high for 10 `en` pulses → 8 writes to bank 0 at `addr` 0..7, pulses 9-10 ignored; then `rdy`=1, `rdy_bank`=0, `rdy_len`=8.
- Window with 5 `en`, then `sinc` low → `rdy_len`=5. Next window goes to bank 1. `ack` → `rdy_bank`=1 after bank 1 closes.
- Three full windows with no `ack` → banks 0 and 1 full, third window gives no `we` and `ovf`=1. `ack` → `rdy_bank`=1, `ovf` still 1.
- Both banks full, `ack` in the same cycle the `sinc` rise is sampled → bank 0 captures normally, `ovf` stays 0.
- Zero-sample window (`sinc` high 3 cycles, no `en`) → no `rdy`, `wr_ptr` unchanged.
- `rst` asserted after 4 writes into bank 0 → all outputs at reset values. Next window writes bank 0 from `addr` 0.
